// File: rtl/rf_init_sequencer_pkg.sv
// Shared types and constants for the RF power-up / register-init sequencer.
package rf_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RST,
    WAIT_PRE,
    WAIT_POST,
    FETCH,
    LOAD,
    PRESENT,
    DONE
  } state_e;

  // Command word layout: [23:8] register address, [7:0] register data.
  localparam int unsigned CMD_ADDR_MSB = 23;
  localparam int unsigned CMD_ADDR_LSB = 8;
  localparam int unsigned CMD_DATA_MSB = 7;

  localparam logic [23:0] CMD_TERMINATOR = 24'hFF_FFFF;

  localparam int unsigned DEF_NUM_CMDS     = 368;
  localparam int unsigned DEF_RESET_CYCLES = 2000;
  localparam int unsigned DEF_READY_WAIT   = 200;
  localparam int unsigned DEF_CMD_W        = 24;
  localparam int unsigned DEF_ADDR_W       = 9;

  // Wait counter only has to hold N-1 of the longer wait.
  function automatic int unsigned wait_cnt_width(input int unsigned a,
                                                 input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rf_init_sequencer_if.sv
// Command handshake between the init sequencer and the SPI shifter.
interface rf_cmd_if #(
  parameter int unsigned CMD_W = 24
);
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/rf_init_sequencer_wait_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module wait_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rf_init_sequencer.sv
// RF chip bring-up sequencer: XRESET/XREADY timing, then streams the
// register-init ROM to the SPI shifter one command at a time.
module rf_init_sequencer
  import rf_init_pkg::*;
#(
  parameter int unsigned NUM_CMDS     = DEF_NUM_CMDS,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned READY_WAIT   = DEF_READY_WAIT,
  parameter int unsigned CMD_W        = DEF_CMD_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CMD_W-1:0]  rom_data,
  output logic              xreset,
  output logic              xready,
  rf_cmd_if.master          cmd,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cmd_count
);

  localparam int unsigned WAIT_W = wait_cnt_width(RESET_CYCLES, READY_WAIT);
  localparam logic [WAIT_W-1:0] RST_LOAD = WAIT_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0] RDY_LOAD = WAIT_W'(READY_WAIT - 1);
  localparam logic [ADDR_W:0]   CMD_LAST = (ADDR_W + 1)'(NUM_CMDS);
  localparam logic [CMD_W-1:0]  TERM     = CMD_W'(CMD_TERMINATOR);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [CMD_W-1:0]    data_q, data_d;
  logic [ADDR_W:0]     idx_inc;
  logic                tmr_load;
  logic [WAIT_W-1:0]   tmr_val;
  logic                tmr_expired;

  wait_timer #(
    .W (WAIT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign idx_inc = {1'b0, idx_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = RST_LOAD;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = HOLD_RST;
          cnt_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = RST_LOAD;
        end
      end
      HOLD_RST: begin
        if (tmr_expired) begin
          state_d  = WAIT_PRE;
          tmr_load = 1'b1;
          tmr_val  = RDY_LOAD;
        end
      end
      WAIT_PRE: begin
        if (tmr_expired) begin
          state_d  = WAIT_POST;
          tmr_load = 1'b1;
          tmr_val  = RDY_LOAD;
        end
      end
      WAIT_POST: begin
        if (tmr_expired) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        // Terminator ends the run without ever reaching cmd_data.
        if (rom_data == TERM) begin
          state_d = DONE;
        end else begin
          data_d  = rom_data;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (cmd.cmd_ready) begin
          if (cnt_q != CMD_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (idx_inc == CMD_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc[ADDR_W-1:0];
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    xreset = 1'b1;
    xready = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        xreset = 1'b0;
        xready = 1'b0;
        busy   = 1'b0;
      end
      HOLD_RST: begin
        xreset = 1'b0;
        xready = 1'b0;
      end
      WAIT_PRE: begin
        xready = 1'b0;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        xreset = 1'b1;
      end
    endcase
  end

  assign cmd.cmd_valid = (state_q == PRESENT);
  assign cmd.cmd_data  = data_q;
  assign rom_addr      = idx_q;
  assign cmd_count     = cnt_q;

endmodule

// File: doc/rf_init_sequencer.md
# rf_init_sequencer

Power-up sequencer that sits directly upstream of the SPI shifter. It drives the RF chip's XRESET/XREADY bring-up timing, then walks the register-init command ROM (`data.mem` image, 24-bit entries: 16-bit address, 8-bit data) one entry at a time. Each command is handed to the SPI shifter over a valid/ready handshake, and `done` is raised when the table is exhausted.

## Interface
- `NUM_CMDS`, 368: number of ROM entries to walk.
- `RESET_CYCLES`, 2000: cycles XRESET is held low after `start`.
- `READY_WAIT`, 200: cycles waited before XREADY rises, and again after it rises before the first command.
- `CMD_W`, 24: command width.
- `ADDR_W`, 9: ROM address width; must satisfy 2^ADDR_W ≥ NUM_CMDS.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin the sequence; sampled only in IDLE or DONE.
- `rom_addr` out ADDR_W: command ROM read address.
- `rom_data` in CMD_W: ROM read data, valid one cycle after `rom_addr` (synchronous ROM).
- `xreset` out 1: RF chip reset, active-low.
- `xready` out 1: RF chip ready strobe level.
- `cmd_valid` out 1: command available to the SPI shifter.
- `cmd_data` out CMD_W: command; [23:8] register address, [7:0] data.
- `cmd_ready` in 1: SPI shifter accepts the command.
- `busy` out 1: sequence in progress.
- `done` out 1: all commands delivered; held until the next `start` or reset.
- `cmd_count` out ADDR_W+1: number of commands transferred in this run.

## Operation
- States: IDLE, HOLD_RST, WAIT_PRE, WAIT_POST, FETCH, LOAD, PRESENT, DONE.
- All outputs are Moore outputs, decoded from registered state, or are registers themselves.
- **IDLE:** `xreset`=0, `xready`=0, `busy`=0. `start`=1 moves to HOLD_RST.
- **HOLD_RST:** `xreset`=0 for exactly RESET_CYCLES cycles, then moves to WAIT_PRE.
- **WAIT_PRE:** `xreset`=1 for READY_WAIT cycles, then moves to WAIT_POST.
- **WAIT_POST:** `xready`=1 (and stays 1 until IDLE or reset) for READY_WAIT cycles. Clears the index, then moves to FETCH.
- **FETCH:** drives `rom_addr`=index, then moves to LOAD.
- **LOAD:** captures `rom_data` into `cmd_data`, then moves to PRESENT.
- **PRESENT:** `cmd_valid`=1 and `cmd_data` is stable until `cmd_valid`&&`cmd_ready`. On that transfer:
  - `cmd_count`+1 and index+1.
  - Moves to DONE if index+1 == NUM_CMDS, otherwise to FETCH.
- **Terminator:** a LOAD that captures 24'hFFFFFF goes straight to DONE. The terminator is never presented and not counted.
- **DONE:** `done`=1, `busy`=0, `xreset`=1, `xready`=1. `start` restarts at HOLD_RST and clears `done` and `cmd_count`.
- `start` is ignored in every other state.
- `busy`=1 in HOLD_RST through PRESENT.
- Wait counter: one down-counter shared by HOLD_RST, WAIT_PRE and WAIT_POST. It is loaded with N-1 on state entry and exits at 0. Width is clog2(max(RESET_CYCLES, READY_WAIT)).

## Timing
- Reset values: state=IDLE, `xreset`=0, `xready`=0, `cmd_valid`=0, `cmd_data`=0, `rom_addr`=0, `busy`=0, `done`=0, `cmd_count`=0.
- `start` sampled at edge k: HOLD_RST is active from k+1. `xreset` is low for cycles k+1…k+RESET_CYCLES and rises at edge k+1+RESET_CYCLES.
- `xready` rises READY_WAIT cycles after `xreset`. The first FETCH comes READY_WAIT cycles after that.
- Per command: FETCH→LOAD→PRESENT, so `cmd_valid` is asserted 2 cycles after entering FETCH. Minimum spacing between transfers is 3 cycles.
- `cmd_valid` is deasserted the cycle after a transfer. It never drops without a transfer.
- `cmd_ready` asserted outside PRESENT has no effect.
- Reset asserted mid-sequence, including mid-handshake: outputs go to reset values immediately (asynchronously), so `xreset` returns low.
- `cmd_count` saturates at NUM_CMDS. The index never wraps past NUM_CMDS-1.

## Structure
- Package `rf_init_pkg`:
  - state enum;
  - `CMD_ADDR_MSB`=23, `CMD_ADDR_LSB`=8, `CMD_DATA_MSB`=7;
  - `CMD_TERMINATOR`=24'hFFFFFF;
  - default timing constants.
- Sub-module `wait_timer`: load/decrement/expire down-counter, instantiated once.

## Test plan
Test parameters: RESET_CYCLES=20, READY_WAIT=5, NUM_CMDS=4, ROM = {0x0A0001, 0x0B0002, 0x0C0003, 0x0D0004}.
- **Nominal:** `start` pulse at edge 10 with `cmd_ready` tied 1 →
  - `xreset` low through edge 30, high from edge 31;
  - `xready` high 5 cycles later;
  - 4 transfers carrying 0x0A0001…0x0D0004 in order;
  - `done`=1, `cmd_count`=4.
- **Backpressure:** `cmd_ready` held 0 for 10 cycles on command 2 → `cmd_valid` stays 1 and `cmd_data` stays 0x0B0002 for all 10 cycles; exactly one transfer.
- **Terminator:** ROM[2]=0xFFFFFF → 2 transfers, then `done`=1 with `cmd_count`=2; 0xFFFFFF never appears with `cmd_valid`=1.
- **Start ignored and restart:** `start` pulsed while in WAIT_PRE causes no timing change. `start` pulsed in DONE gives:
  - `done`→0 and `cmd_count`→0;
  - `xreset` low for 20 cycles;
  - full replay of the 4 commands.
- **Reset mid-operation:** `reset` low during PRESENT of command 3 → same cycle `xreset`=0, `xready`=0, `cmd_valid`=0, `busy`=0. After release the block is in IDLE.
